// File: rtl/instr_fetch.sv
// Instruction-fetch stage: owns the PC, issues one imem request per instruction,
// captures the returned word into IR and hands it to decode over valid/ready.
//
// state  | meaning
// FETCH  | choose next action: launch request at pc, or stop if halt is set
// WAIT   | request outstanding; capture or discard (squash) the response
// HOLD   | ir_valid high, waiting for ir_ready (or a redirect)
// HALTED | fetch stopped until reset
module instr_fetch #(
    parameter int              PC_W     = 32,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            reset,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic            imem_rvalid,
    input  logic [31:0]     imem_rdata,
    output logic [31:0]     ir,
    output logic [PC_W-1:0] ir_pc,
    output logic            ir_valid,
    input  logic            ir_ready,
    input  logic            redirect_valid,
    input  logic [PC_W-1:0] redirect_pc,
    input  logic            halt,
    output logic            halted
);

    typedef enum logic [1:0] {
        FETCH  = 2'd0,
        WAIT   = 2'd1,
        HOLD   = 2'd2,
        HALTED = 2'd3
    } state_t;

    state_t          state, state_nx;
    logic [PC_W-1:0] pc, pc_nx;
    logic            squash, squash_nx;
    logic            imem_req_nx;
    logic [PC_W-1:0] imem_addr_nx;
    logic [31:0]     ir_nx;
    logic [PC_W-1:0] ir_pc_nx;
    logic            ir_valid_nx;
    logic            halted_nx;
    logic [PC_W-1:0] redir_target;

    assign redir_target = redirect_pc & ~PC_W'(3);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= FETCH;
            pc        <= RESET_PC;
            squash    <= 1'b0;
            imem_req  <= 1'b0;
            imem_addr <= RESET_PC;
            ir        <= '0;
            ir_pc     <= '0;
            ir_valid  <= 1'b0;
            halted    <= 1'b0;
        end else begin
            state     <= state_nx;
            pc        <= pc_nx;
            squash    <= squash_nx;
            imem_req  <= imem_req_nx;
            imem_addr <= imem_addr_nx;
            ir        <= ir_nx;
            ir_pc     <= ir_pc_nx;
            ir_valid  <= ir_valid_nx;
            halted    <= halted_nx;
        end
    end

    always_comb begin
        state_nx     = state;
        pc_nx        = pc;
        squash_nx    = squash;
        imem_req_nx  = 1'b0;
        imem_addr_nx = imem_addr;
        ir_nx        = ir;
        ir_pc_nx     = ir_pc;
        ir_valid_nx  = ir_valid;
        halted_nx    = halted;

        case (state)
            FETCH: begin
                if (halt) begin
                    state_nx  = HALTED;
                    halted_nx = 1'b1;
                end else begin
                    // A redirect seen here still lets the old-pc request go out; squash its reply.
                    imem_req_nx  = 1'b1;
                    imem_addr_nx = pc;
                    state_nx     = WAIT;
                    if (redirect_valid) begin
                        pc_nx     = redir_target;
                        squash_nx = 1'b1;
                    end
                end
            end
            WAIT: begin
                if (imem_rvalid) begin
                    if (squash || redirect_valid) begin
                        squash_nx = 1'b0;
                        state_nx  = FETCH;
                    end else begin
                        ir_nx       = imem_rdata;
                        ir_pc_nx    = pc;
                        pc_nx       = pc + PC_W'(4);
                        ir_valid_nx = 1'b1;
                        state_nx    = HOLD;
                    end
                end else if (redirect_valid) begin
                    squash_nx = 1'b1;
                end
                if (redirect_valid) begin
                    pc_nx = redir_target;
                end
            end
            HOLD: begin
                if (ir_ready || redirect_valid) begin
                    ir_valid_nx = 1'b0;
                    if (ir_ready && halt) begin
                        state_nx  = HALTED;
                        halted_nx = 1'b1;
                    end else begin
                        state_nx = FETCH;
                    end
                end
                if (redirect_valid) begin
                    pc_nx = redir_target;
                end
            end
            HALTED: begin
                halted_nx = 1'b1;
            end
            default: begin
                state_nx = FETCH;
            end
        endcase
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: behavioural memory with variable latency, an
// instruction-stream reference model checked every cycle, and directed scenarios.
module tb_instr_fetch;

    localparam int          PC_W     = 32;
    localparam logic [31:0] RESET_PC = 32'h0;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] ir;
    logic [31:0] ir_pc;
    logic        ir_valid;
    logic        ir_ready;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        halt;
    logic        halted;

    instr_fetch #(.PC_W(PC_W), .RESET_PC(RESET_PC)) dut (
        .clk(clk), .reset(reset),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .ir(ir), .ir_pc(ir_pc), .ir_valid(ir_valid), .ir_ready(ir_ready),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .halt(halt), .halted(halted)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Program image: address 0 holds the known first instruction, everything else a hash.
    function automatic logic [31:0] memf(input logic [31:0] a);
        if (a == 32'h0) return 32'h0400_0064;
        return (a * 32'h9E37_79B1) ^ 32'hA5A5_0000;
    endfunction

    // ---------------- reference model / monitor (negedge) ----------------
    logic [31:0] exp_pc;
    logic        prev_valid, prev_ready, prev_req, last_redir;
    logic [31:0] last_tgt, prev_ir, prev_irpc, prev_addr;
    int          req_n = 0, pres_n = 0, req_cyc = 0, pres_cyc = 0;
    logic [31:0] req_addr, pres_ir, pres_pc;
    int          mcnt = 0;

    always @(negedge clk) begin
        if (reset) begin
            chk("reset_ctl", {29'b0, imem_req, ir_valid, halted}, 32'h0);
            chk("reset_ir", ir, 32'h0);
            chk("reset_ir_pc", ir_pc, 32'h0);
            exp_pc     = RESET_PC;
            prev_valid = 1'b0;
            prev_ready = 1'b0;
            prev_req   = 1'b0;
            last_redir = 1'b0;
        end else begin
            if (ir_valid && !prev_valid) begin
                chk("pres_pc", ir_pc, exp_pc);
                chk("pres_word", ir, memf(ir_pc));
                chk("pres_after_redirect", 32'(last_redir), 32'h0);
                exp_pc   = ir_pc + 32'd4;
                pres_n++;
                pres_cyc = cyc;
                pres_ir  = ir;
                pres_pc  = ir_pc;
            end
            if (ir_valid && prev_valid) begin
                chk("hold_ir", ir, prev_ir);
                chk("hold_ir_pc", ir_pc, prev_irpc);
            end
            if (prev_valid && (prev_ready || last_redir))
                chk("consumed_drop", 32'(ir_valid), 32'h0);
            if (imem_req) begin
                chk("req_addr", imem_addr, exp_pc);
                chk("req_single", {30'b0, prev_req, (mcnt != 0)}, 32'h0);
                req_n++;
                req_cyc  = cyc;
                req_addr = imem_addr;
            end
            if (halted)
                chk("halted_quiet", {30'b0, imem_req, ir_valid}, 32'h0);
            if (last_redir)
                exp_pc = last_tgt & 32'hFFFF_FFFC;
            last_redir = redirect_valid;
            last_tgt   = redirect_pc;
            prev_valid = ir_valid;
            prev_ready = ir_ready;
            prev_req   = imem_req;
            prev_addr  = imem_addr;
            prev_ir    = ir;
            prev_irpc  = ir_pc;
        end
    end

    // ---------------- instruction memory ----------------
    int          lat = 1;        // 0 = random 1..4 per request
    int          inj_cyc = -1;   // cycle in which a stray response is injected
    logic [31:0] paddr;

    initial begin
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
        forever begin
            @(posedge clk);
            #1;
            imem_rvalid = 1'b0;
            if (reset) begin
                mcnt = 0;
            end else begin
                if (prev_req) begin
                    mcnt  = (lat == 0) ? int'($urandom_range(1, 4)) : lat;
                    paddr = prev_addr;
                end
                if (mcnt > 0) begin
                    mcnt--;
                    if (mcnt == 0) begin
                        imem_rvalid = 1'b1;
                        imem_rdata  = memf(paddr);
                    end
                end
            end
            if (cyc == inj_cyc) begin
                imem_rvalid = 1'b1;
                imem_rdata  = 32'hDEAD_BEEF;
            end
        end
    end

    // ---------------- bounded wait helpers ----------------
    task automatic wait_req(output int c, output logic [31:0] a);
        int start;
        start = req_n;
        c = -1;
        a = 32'h0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            #1;
            if (req_n != start) begin
                c = req_cyc;
                a = req_addr;
                return;
            end
        end
        tests++;
        fails++;
        $display("FAIL wait_req: no imem_req within 200 cycles (cycle %0d)", cyc);
    endtask

    task automatic wait_pres(output int c, output logic [31:0] w, output logic [31:0] p);
        int start;
        start = pres_n;
        c = -1;
        w = 32'h0;
        p = 32'h0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            #1;
            if (pres_n != start) begin
                c = pres_cyc;
                w = pres_ir;
                p = pres_pc;
                return;
            end
        end
        tests++;
        fails++;
        $display("FAIL wait_pres: no ir_valid within 200 cycles (cycle %0d)", cyc);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        int          c0, c1, c2, p, ts, n0, p_start;
        logic [31:0] a0, a1, a2, w, wp;

        reset          = 1'b1;
        ir_ready       = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        halt           = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        ir_ready = 1'b1;
        reset    = 1'b0;

        // 1: straight-line fetch with 1-cycle memory
        wait_req(c0, a0);
        chk("t1_addr0", a0, 32'h0);
        wait_pres(p, w, wp);
        chk("t1_latency", 32'(p - c0), 32'd2);
        chk("t1_ir", w, 32'h0400_0064);
        chk("t1_ir_pc", wp, 32'h0);
        wait_req(c1, a1);
        chk("t1_addr1", a1, 32'h4);
        chk("t1_period1", 32'(c1 - c0), 32'd4);
        wait_req(c2, a2);
        chk("t1_addr2", a2, 32'h8);
        chk("t1_period2", 32'(c2 - c1), 32'd4);

        // 2: backpressure in HOLD
        @(posedge clk); #1;
        ir_ready = 1'b0;
        wait_pres(p, w, wp);
        n0 = req_n;
        repeat (5) @(negedge clk);
        #1;
        chk("t2_ir_stable", ir, w);
        chk("t2_ir_pc_stable", ir_pc, wp);
        chk("t2_valid_held", 32'(ir_valid), 32'h1);
        chk("t2_no_req", 32'(req_n - n0), 32'h0);
        @(posedge clk); #1;
        ir_ready = 1'b1;
        ts = cyc;
        wait_req(c0, a0);
        chk("t2_resume_cycle", 32'(c0 - ts), 32'd2);
        chk("t2_resume_addr", a0, wp + 32'd4);
        lat = 3;

        // 3: redirect while a 3-cycle request is outstanding
        wait_req(c0, a0);
        n0 = pres_n;
        @(posedge clk); #1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h100;
        @(posedge clk); #1;
        redirect_valid = 1'b0;
        wait_req(c1, a1);
        chk("t3_target", a1, 32'h100);
        chk("t3_refetch_cycle", 32'(c1 - c0), 32'd5);
        chk("t3_squashed", 32'(pres_n - n0), 32'h0);
        @(posedge clk); #1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h103;
        @(posedge clk); #1;
        redirect_valid = 1'b0;
        wait_req(c2, a2);
        chk("t3_aligned_target", a2, 32'h100);
        chk("t3_squashed2", 32'(pres_n - n0), 32'h0);
        lat = 1;

        // 4: redirect together with ir_ready in HOLD
        @(posedge clk); #1;
        ir_ready = 1'b0;
        wait_pres(p, w, wp);
        chk("t4_held_pc", wp, 32'h100);
        @(posedge clk); #1;
        ir_ready       = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h200;
        @(posedge clk); #1;
        redirect_valid = 1'b0;
        wait_req(c0, a0);
        chk("t4_target", a0, 32'h200);
        wait_pres(p, w, wp);
        chk("t4_next_pc", wp, 32'h200);
        lat = 2;

        // 5: halt raised while waiting for memory
        wait_req(c0, a0);
        chk("t5_addr", a0, 32'h204);
        @(posedge clk); #1;
        halt = 1'b1;
        wait_pres(p, w, wp);
        chk("t5_delivered_pc", wp, 32'h204);
        @(negedge clk); #1;
        chk("t5_halted", 32'(halted), 32'h1);
        n0 = req_n;
        @(posedge clk); #1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h300;
        @(posedge clk); #1;
        redirect_valid = 1'b0;
        repeat (6) @(negedge clk);
        #1;
        chk("t5_no_req", 32'(req_n - n0), 32'h0);
        chk("t5_still_halted", {30'b0, halted, ir_valid}, 32'h2);
        chk("t5_ir_kept", ir, w);

        // 6: reset out of HALTED, PC wrap, reset mid-WAIT with a stray response
        @(posedge clk); #1;
        reset = 1'b1;
        #1;
        chk("t6_async_halted", 32'(halted), 32'h0);
        chk("t6_async_ir", ir, 32'h0);
        halt = 1'b0;
        lat  = 1;
        @(posedge clk);
        @(posedge clk); #1;
        reset = 1'b0;
        wait_req(c0, a0);
        chk("t6_restart", a0, RESET_PC);
        @(posedge clk); #1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFE;
        @(posedge clk); #1;
        redirect_valid = 1'b0;
        wait_req(c0, a0);
        chk("t6_top_addr", a0, 32'hFFFF_FFFC);
        wait_pres(p, w, wp);
        chk("t6_top_pc", wp, 32'hFFFF_FFFC);
        wait_req(c0, a0);
        chk("t6_wrap", a0, 32'h0);
        lat = 4;
        wait_req(c0, a0);
        reset = 1'b1;
        #1;
        chk("t6_mid_req", 32'(imem_req), 32'h0);
        chk("t6_mid_ir", ir, 32'h0);
        chk("t6_mid_ir_pc", ir_pc, 32'h0);
        chk("t6_mid_valid", 32'(ir_valid), 32'h0);
        lat = 1;
        @(posedge clk); #1;
        inj_cyc = cyc + 1;
        @(posedge clk); #1;
        reset = 1'b0;
        n0 = pres_n;
        wait_req(c0, a0);
        chk("t6_reset_pc", a0, RESET_PC);
        chk("t6_late_ignored", 32'(pres_n - n0), 32'h0);
        wait_pres(p, w, wp);
        chk("t6_first_ir", w, 32'h0400_0064);
        chk("t6_first_ir_pc", wp, 32'h0);

        // random traffic: latency, backpressure and redirects
        lat     = 0;
        p_start = pres_n;
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk); #1;
            ir_ready       = ($urandom_range(0, 9) < 6);
            redirect_valid = ($urandom_range(0, 11) == 0);
            redirect_pc    = ($urandom_range(0, 1) == 1) ? $urandom : {16'h0, 16'($urandom)};
        end
        redirect_valid = 1'b0;
        ir_ready       = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        chk("rand_progress", 32'((pres_n - p_start) > 100), 32'h1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
